// File: rtl/adder_pkg.sv
// Shared widths, the write-back entry type and the opcode constants used by
// execute and the write-back/register-file slice.
package adder_pkg;

    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    localparam logic [3:0] OP_INC = 4'b0001;
    localparam logic [3:0] OP_DEC = 4'b0010;

endpackage

// File: rtl/wb_fifo.sv
// In-order write buffer between execute and the register file. Also offers a
// combinational lookup returning the newest buffered entry for an address.
module wb_fifo
    import adder_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  wb_entry_t                  push_entry,
    input  logic                       pop,
    output wb_entry_t                  head_entry,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    input  logic [ADDR_W-1:0]          lookup_addr,
    output logic                       lookup_hit,
    output logic [DATA_W-1:0]          lookup_data
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full       = (count == CNT_W'(DEPTH));
    assign empty      = (count == '0);
    assign do_push    = push && !full;
    assign do_pop     = pop && !empty;
    assign head_entry = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Walk from oldest to newest so the newest matching entry wins.
    always_comb begin
        int               sum;
        logic [PTR_W-1:0] idx;
        lookup_hit  = 1'b0;
        lookup_data = '0;
        sum         = 0;
        idx         = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i < int'(count)) begin
                sum = int'(rd_ptr) + i;
                if (sum >= DEPTH) begin
                    sum = sum - DEPTH;
                end
                idx = PTR_W'(sum);
                if (mem[idx].addr == lookup_addr) begin
                    lookup_hit  = 1'b1;
                    lookup_data = mem[idx].data;
                end
            end
        end
    end

endmodule

// File: rtl/writeback_regfile.sv
// Write-back stage: buffers execute results, drains them into a 16x8 register
// file, and serves a registered read port that sees all accepted writes.
module writeback_regfile
    import adder_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wb_valid,
    input  logic [ADDR_W-1:0]          wb_addr,
    input  logic [DATA_W-1:0]          wb_data,
    output logic                       wb_ready,
    input  logic                       host_we,
    input  logic [ADDR_W-1:0]          host_addr,
    input  logic [DATA_W-1:0]          host_wdata,
    input  logic [ADDR_W-1:0]          rd_addr,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       pending,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    logic [DATA_W-1:0] regs [NUM_REGS];
    wb_entry_t         push_entry;
    wb_entry_t         head_entry;
    logic              accept;
    logic              drain;
    logic              fifo_full;
    logic              fifo_empty;
    logic              hit;
    logic [DATA_W-1:0] hit_data;
    logic [DATA_W-1:0] rd_next;

    // Ready depends only on stored occupancy; a same-cycle drain does not reopen it.
    assign wb_ready   = !fifo_full;
    assign pending    = !fifo_empty;
    assign accept     = wb_valid && wb_ready;
    assign drain      = !host_we && !fifo_empty;
    assign push_entry = '{addr: wb_addr, data: wb_data};

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (accept),
        .push_entry  (push_entry),
        .pop         (drain),
        .head_entry  (head_entry),
        .count       (count),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .lookup_addr (rd_addr),
        .lookup_hit  (hit),
        .lookup_data (hit_data)
    );

    // Host owns the write port when active; the drain simply waits a cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (host_we) begin
            regs[host_addr] <= host_wdata;
        end else if (drain) begin
            regs[head_entry.addr] <= head_entry.data;
        end
    end

    // Newest-first: incoming result, buffered entries, host write, array.
    always_comb begin
        rd_next = regs[rd_addr];
        if (accept && (wb_addr == rd_addr)) begin
            rd_next = wb_data;
        end else if (hit) begin
            rd_next = hit_data;
        end else if (host_we && (host_addr == rd_addr)) begin
            rd_next = host_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= rd_next;
        end
    end

endmodule

// File: tb/tb_writeback_regfile.sv
// Bench for writeback_regfile: directed scenarios followed by random traffic,
// checked every cycle against an architectural model of the register file.
module tb_writeback_regfile;

    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          wb_valid;
    logic [3:0]    wb_addr;
    logic [7:0]    wb_data;
    logic          wb_ready;
    logic          host_we;
    logic [3:0]    host_addr;
    logic [7:0]    host_wdata;
    logic [3:0]    rd_addr;
    logic [7:0]    rd_data;
    logic          pending;
    logic [CW-1:0] count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] a;
        logic [7:0] d;
    } ent_t;

    logic [7:0] m_regs [16];
    ent_t       m_q [$];
    logic [7:0] m_rd;

    writeback_regfile #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .wb_valid   (wb_valid),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .wb_ready   (wb_ready),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .pending    (pending),
        .count      (count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench time limit exceeded");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, predict, clock, update model, compare outputs.
    task automatic cyc(input logic r, input logic wv, input logic [3:0] wa, input logic [7:0] wd,
                       input logic hw, input logic [3:0] ha, input logic [7:0] hd,
                       input logic [3:0] ra);
        logic [7:0] arch [16];
        logic       acc;
        ent_t       e;
        rst = r; wb_valid = wv; wb_addr = wa; wb_data = wd;
        host_we = hw; host_addr = ha; host_wdata = hd; rd_addr = ra;
        acc = !r && wv && (m_q.size() < DEPTH);
        // Expected read: value once every accepted write has committed in order.
        arch = m_regs;
        if (hw) arch[ha] = hd;
        foreach (m_q[k]) arch[m_q[k].a] = m_q[k].d;
        if (acc) arch[wa] = wd;
        @(posedge clk);
        #1;
        if (r) begin
            foreach (m_regs[k]) m_regs[k] = 8'h00;
            m_q.delete();
            m_rd = 8'h00;
        end else begin
            m_rd = arch[ra];
            if (hw) begin
                m_regs[ha] = hd;
            end else if (m_q.size() > 0) begin
                e = m_q.pop_front();
                m_regs[e.a] = e.d;
            end
            if (acc) begin
                e.a = wa; e.d = wd;
                m_q.push_back(e);
            end
        end
        check("rd_data", 32'(rd_data), 32'(m_rd));
        check("count", 32'(count), 32'(m_q.size()));
        check("wb_ready", 32'(wb_ready), 32'(m_q.size() < DEPTH));
        check("pending", 32'(pending), 32'(m_q.size() > 0));
    endtask

    task automatic idle(input logic [3:0] ra);
        cyc(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 8'h00, ra);
    endtask

    initial begin
        logic       r, wv, hw;
        logic [3:0] wa, ha, ra;
        logic [7:0] wd, hd;

        foreach (m_regs[k]) m_regs[k] = 8'h00;
        m_rd = 8'h00;
        @(posedge clk);
        #1;
        // Reset cycle also offers a transfer, which must be dropped.
        cyc(1'b1, 1'b1, 4'h6, 8'h5A, 1'b0, 4'h0, 8'h00, 4'h6);
        cyc(1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 8'h00, 4'h0);
        check("ready_after_reset", 32'(wb_ready), 32'd1);
        check("count_after_reset", 32'(count), 32'd0);

        for (int i = 0; i < 16; i++) begin
            idle(4'(i));
            check("idle_read_zero", 32'(rd_data), 32'h00);
        end

        // Single write then three reads of R3.
        cyc(1'b0, 1'b1, 4'h3, 8'h2A, 1'b0, 4'h0, 8'h00, 4'h0);
        check("r3_count_1", 32'(count), 32'd1);
        idle(4'h3);
        check("r3_read_a", 32'(rd_data), 32'h2A);
        check("r3_count_0", 32'(count), 32'd0);
        idle(4'h3);
        check("r3_read_b", 32'(rd_data), 32'h2A);
        idle(4'h3);
        check("r3_read_c", 32'(rd_data), 32'h2A);

        // Read-during-write bypass.
        cyc(1'b0, 1'b1, 4'h5, 8'h7F, 1'b0, 4'h0, 8'h00, 4'h5);
        check("r5_bypass", 32'(rd_data), 32'h7F);
        idle(4'h0);

        // Host holds the port for 4 cycles while execute pushes into R1.
        cyc(1'b0, 1'b1, 4'h1, 8'h01, 1'b1, 4'h0, 8'h11, 4'h1);
        cyc(1'b0, 1'b1, 4'h1, 8'h02, 1'b1, 4'h0, 8'h11, 4'h1);
        cyc(1'b0, 1'b1, 4'h1, 8'h03, 1'b1, 4'h0, 8'h11, 4'h1);
        check("host_hold_full_ready", 32'(wb_ready), 32'd0);
        cyc(1'b0, 1'b1, 4'h1, 8'h03, 1'b1, 4'h0, 8'h11, 4'h1);
        check("host_hold_count", 32'(count), 32'd2);
        check("host_hold_r1", 32'(rd_data), 32'h02);
        idle(4'h1);
        idle(4'h0);
        check("drain_done_count", 32'(count), 32'd0);
        check("drain_r0", 32'(rd_data), 32'h11);
        idle(4'h1);
        check("drain_r1", 32'(rd_data), 32'h02);
        cyc(1'b0, 1'b1, 4'h1, 8'h03, 1'b0, 4'h0, 8'h00, 4'h1);
        check("third_push_r1", 32'(rd_data), 32'h03);
        idle(4'h0);

        // Buffered R7 beats a later host write to R7.
        cyc(1'b0, 1'b1, 4'h7, 8'h44, 1'b0, 4'h0, 8'h00, 4'h0);
        cyc(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 4'h7, 8'h99, 4'h7);
        check("r7_bypass_over_host", 32'(rd_data), 32'h44);
        idle(4'h7);
        idle(4'h7);
        check("r7_persist", 32'(rd_data), 32'h44);

        // Reset with two buffered entries.
        cyc(1'b0, 1'b1, 4'h2, 8'hAA, 1'b1, 4'hF, 8'h01, 4'h0);
        cyc(1'b0, 1'b1, 4'h4, 8'hBB, 1'b1, 4'hF, 8'h01, 4'h0);
        check("pre_reset_count", 32'(count), 32'd2);
        cyc(1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 8'h00, 4'h2);
        check("mid_reset_count", 32'(count), 32'd0);
        check("mid_reset_ready", 32'(wb_ready), 32'd1);
        idle(4'h2);
        check("mid_reset_r2", 32'(rd_data), 32'h00);
        idle(4'h4);
        check("mid_reset_r4", 32'(rd_data), 32'h00);

        // Random traffic over a narrow address range to force collisions.
        for (int n = 0; n < 600; n++) begin
            r  = ($urandom_range(0, 79) == 0);
            wv = ($urandom_range(0, 9) < 6);
            hw = ($urandom_range(0, 9) < 3);
            wa = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
            ha = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
            ra = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
            wd = 8'($urandom);
            hd = 8'($urandom);
            cyc(r, wv, wa, wd, hw, ha, hd, ra);
        end

        // Flush and sweep every register through the read port.
        idle(4'h0);
        idle(4'h0);
        idle(4'h0);
        for (int i = 0; i < 16; i++) begin
            idle(4'(i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/writeback_regfile.md
Name: writeback_regfile

Overview:
- Receiving end of the execute stage's result/write-address output.
- Accepts ALU results through a valid/ready handshake and holds them in a small in-order write buffer.
- Drains the buffer into a 16x8 register file, one entry per cycle.
- Provides a registered read port back to execute with full bypass of pending writes, plus a host/debug write port that has priority on the register-file write port.

Parameters:
DATA_W, 8, register and result width
ADDR_W, 4, register address width (2**ADDR_W registers)
DEPTH, 2, write-buffer entries; legal range 2..8

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
wb_valid  in  1  execute presents a result this cycle
wb_addr  in  ADDR_W  destination register (execute's write_addr)
wb_data  in  DATA_W  result value
wb_ready  out  1  buffer can accept; a transfer occurs when wb_valid and wb_ready are both 1
host_we  in  1  host/debug direct register write
host_addr  in  ADDR_W  host write address
host_wdata  in  DATA_W  host write data
rd_addr  in  ADDR_W  read address (supplies execute's data input)
rd_data  out  DATA_W  registered read result, valid the cycle after rd_addr is sampled
pending  out  1  buffer non-empty
count  out  $clog2(DEPTH+1)  buffer occupancy

Behaviour:
- Reset (rst=1 at edge): clears all registers to 0, count to 0, rd_data to 0, and discards buffered entries. pending=0; wb_ready=1 the cycle after reset. A transfer offered in the reset cycle is dropped.
- wb_ready = (count < DEPTH):
  - pure function of registered state; no combinational path from wb_valid, host_we or the drain.
  - When full, wb_ready stays 0 even if a drain occurs that cycle.
- Push: an accepted transfer appends {wb_addr, wb_data} at the tail. Order is strictly preserved.
- Drain: each cycle with host_we=0 and count>0, the head entry is written to the register file and popped.
  - When host_we=1, the host write goes to the register file and the drain stalls for that cycle.
- Simultaneous push and drain: count unchanged. Push only: count+1. Drain only: count-1.
- Same-address ordering is by commit time. A host write to register R is overwritten later by any buffered entry for R when that entry drains.
- Read priority for rd_data (sampled at the edge, visible next cycle), first match wins:
  1. this cycle's accepted wb transfer with wb_addr==rd_addr
  2. newest buffered entry with matching address
  3. this cycle's host write with host_addr==rd_addr
  4. register file contents
- The read is therefore the architectural value once all currently accepted writes have committed. Read latency is exactly 1 cycle; reads are never stalled.
- No arithmetic is performed on data. Addresses wrap naturally within ADDR_W. A pointer wrap at DEPTH has no visible effect.
- A worst case of DEPTH consecutive host writes with a full buffer is legal; the buffer simply holds its contents.

Decomposition:
- Shared package adder_pkg:
  - DATA_W and ADDR_W constants
  - wb_entry_t typedef {addr, data}
  - opcode constants shared with execute (INC=4'b0001, DEC=4'b0010)
- One sub-module, wb_fifo: DEPTH-entry in-order buffer.
  - Provides push/pop, count, and a combinational "newest match" lookup port used for the read bypass.
- Register array, write-port arbitration and read mux stay in writeback_regfile.

Test Plan:
- Reset then idle: rd_addr=0..15 sequentially -> rd_data=0x00 each following cycle; wb_ready=1, count=0, pending=0.
- Write R3=0x2A (wb_valid one cycle, host idle), then read R3 on each of the next 3 cycles -> rd_data=0x2A in all three; count goes 1 then 0.
- Read-during-write bypass: wb write R5=0x7F with rd_addr=5 in the same cycle -> rd_data=0x7F next cycle.
- Hold host_we=1 (R0=0x11) for 4 cycles while execute pushes R1=0x01, R1=0x02, R1=0x03:
  - first two accepted; wb_ready=0 afterwards; count=2
  - read R1 -> 0x02
  - after host_we drops, drains complete in 2 cycles; R1=0x02, R0=0x11; the third push is accepted only once wb_ready returns to 1.
- Host/buffer ordering: buffer holds R7=0x44; a host write R7=0x99 in the same cycle reads 0x44 via bypass; after the drain, R7=0x44 persists.
- Reset mid-operation: with count=2 (R2=0xAA, R4=0xBB), assert rst one cycle -> count=0, reads of R2 and R4 return 0x00, wb_ready=1.
